// File: rtl/img2col_window_ctrl.sv
// -----------------------------------------------------------------------------
// img2col_window_ctrl
//
// Sequences one register file inside the img2col stage. Pixels arrive on a
// valid/ready stream and are written to consecutive register addresses. Once a
// window is full, the controller pulses a one-cycle snapshot read. It then
// presents the snapshot downstream with a valid/ready handshake. This repeats
// for the configured number of windows per job.
//
// Optional feature (macro IMG2COL_CTRL_ZEROPAD_EN):
//   When defined and the window length is shorter than REG_NUM, the addresses
//   len..REG_NUM-1 are written with zero before the snapshot.
//   When undefined, those addresses keep their stale contents.
//
// Ports
//   clk          clock, rising edge
//   nrst         asynchronous active-low reset
//   start        job start pulse, sampled in IDLE only
//   cfg_len      pixels per window (0 or >REG_NUM clamps to REG_NUM), latched
//   cfg_num_win  windows per job, latched at start
//   pix_valid    input pixel valid
//   pix_data     input pixel
//   pix_ready    controller accepts a pixel this cycle
//   rf_wr_ctrl   register-file write enable      (combinational)
//   rf_r_ctrl    register-file snapshot enable   (registered)
//   rf_adrs      register-file write address     (combinational)
//   rf_in        register-file write data        (combinational)
//   win_valid    register-file outputs hold a complete window (registered)
//   win_ready    downstream consumed the window
//   busy         controller not idle             (registered)
//   done         one-cycle pulse at job end      (registered)
//   win_count    windows presented in this job   (registered)
// -----------------------------------------------------------------------------
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start
// FILL    | accepting pixels into wr_ptr
// PAD     | writing zero to the unused tail (zero-pad build only)
// SNAP    | one-cycle snapshot read of the register file
// PRESENT | window offered downstream, waiting for win_ready
// DONE    | one-cycle done pulse, then back to IDLE

module img2col_window_ctrl #(
   parameter int DATA_W  = 16,
   parameter int REG_NUM = 25,
   parameter int ADDR_W  = 5,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              start,
   input  logic [ADDR_W:0]   cfg_len,
   input  logic [CNT_W-1:0]  cfg_num_win,
   input  logic              pix_valid,
   input  logic [DATA_W-1:0] pix_data,
   output logic              pix_ready,
   output logic              rf_wr_ctrl,
   output logic              rf_r_ctrl,
   output logic [ADDR_W-1:0] rf_adrs,
   output logic [DATA_W-1:0] rf_in,
   output logic              win_valid,
   input  logic              win_ready,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  win_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FILL    = 3'd1,
      S_SNAP    = 3'd2,
      S_PRESENT = 3'd3,
      S_DONE    = 3'd4
`ifdef IMG2COL_CTRL_ZEROPAD_EN
      , S_PAD   = 3'd5
`endif
   } state_t;

   localparam logic [ADDR_W:0]   LEN_MAX   = (ADDR_W+1)'(REG_NUM);
   localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
`ifdef IMG2COL_CTRL_ZEROPAD_EN
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REG_NUM - 1);
`endif

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
   logic [ADDR_W:0]   len_q, len_nxt;
   logic [CNT_W-1:0]  num_q, num_nxt;
   logic [CNT_W-1:0]  win_count_nxt;
   logic [CNT_W-1:0]  win_count_inc;
   logic [ADDR_W:0]   len_clamp;
   logic              last_pix;

   assign len_clamp     = ((cfg_len == '0) || (cfg_len > LEN_MAX)) ? LEN_MAX : cfg_len;
   assign last_pix      = ({1'b0, wr_ptr} == (len_q - LEN_ONE));
   assign win_count_inc = win_count + CNT_ONE;

   always_comb begin
      state_nxt     = state;
      wr_ptr_nxt    = wr_ptr;
      len_nxt       = len_q;
      num_nxt       = num_q;
      win_count_nxt = win_count;
      pix_ready     = 1'b0;
      rf_wr_ctrl    = 1'b0;
      rf_adrs       = '0;
      rf_in         = '0;

      case (state)
         S_IDLE: begin
            if (start) begin
               len_nxt       = len_clamp;
               num_nxt       = cfg_num_win;
               win_count_nxt = '0;
               wr_ptr_nxt    = '0;
               state_nxt     = (cfg_num_win == '0) ? S_DONE : S_FILL;
            end
         end

         S_FILL: begin
            pix_ready  = 1'b1;
            rf_wr_ctrl = pix_valid;
            rf_adrs    = wr_ptr;
            rf_in      = pix_data;
            if (pix_valid) begin
               wr_ptr_nxt = wr_ptr + PTR_ONE;
               if (last_pix) begin
`ifdef IMG2COL_CTRL_ZEROPAD_EN
                  state_nxt = (len_q < LEN_MAX) ? S_PAD : S_SNAP;
`else
                  state_nxt = S_SNAP;
`endif
               end
            end
         end

`ifdef IMG2COL_CTRL_ZEROPAD_EN
         // wr_ptr already points at len after the last pixel, so the tail
         // starts there and ends at the top register.
         S_PAD: begin
            rf_wr_ctrl = 1'b1;
            rf_adrs    = wr_ptr;
            wr_ptr_nxt = wr_ptr + PTR_ONE;
            if (wr_ptr == LAST_ADDR) begin
               state_nxt = S_SNAP;
            end
         end
`endif

         S_SNAP: begin
            state_nxt = S_PRESENT;
         end

         S_PRESENT: begin
            if (win_ready) begin
               win_count_nxt = win_count_inc;
               if (win_count_inc == num_q) begin
                  state_nxt = S_DONE;
               end else begin
                  state_nxt  = S_FILL;
                  wr_ptr_nxt = '0;
               end
            end
         end

         S_DONE: begin
            state_nxt = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // The registered outputs are decoded from the next state. This keeps
   // them cycle-aligned with the state they describe without adding
   // combinational paths to the outputs.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= S_IDLE;
         wr_ptr    <= '0;
         len_q     <= '0;
         num_q     <= '0;
         win_count <= '0;
         win_valid <= 1'b0;
         rf_r_ctrl <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         wr_ptr    <= wr_ptr_nxt;
         len_q     <= len_nxt;
         num_q     <= num_nxt;
         win_count <= win_count_nxt;
         win_valid <= (state_nxt == S_PRESENT);
         rf_r_ctrl <= (state_nxt == S_SNAP);
         done      <= (state_nxt == S_DONE);
         busy      <= (state_nxt != S_IDLE);
      end
   end

endmodule

// File: tb/tb_img2col_window_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for img2col_window_ctrl.
// Expected register-file writes go into a scoreboard queue when pixels are
// driven. A negedge monitor pops them as the DUT writes. Directed checks
// follow the control timing (snapshot, present, done, win_count).
// -----------------------------------------------------------------------------
module tb_img2col_window_ctrl;

   localparam int DW = 16;
   localparam int RN = 25;
   localparam int AW = 5;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          nrst;
   logic          start;
   logic [AW:0]   cfg_len;
   logic [CW-1:0] cfg_num_win;
   logic          pix_valid;
   logic [DW-1:0] pix_data;
   logic          pix_ready;
   logic          rf_wr_ctrl;
   logic          rf_r_ctrl;
   logic [AW-1:0] rf_adrs;
   logic [DW-1:0] rf_in;
   logic          win_valid;
   logic          win_ready;
   logic          busy;
   logic          done;
   logic [CW-1:0] win_count;

   int vectors     = 0;
   int miscompares = 0;
   int wr_cnt      = 0;
   int done_cnt    = 0;

   logic [AW+DW-1:0] exp_q[$];

   img2col_window_ctrl #(.DATA_W(DW), .REG_NUM(RN), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .start      (start),
      .cfg_len    (cfg_len),
      .cfg_num_win(cfg_num_win),
      .pix_valid  (pix_valid),
      .pix_data   (pix_data),
      .pix_ready  (pix_ready),
      .rf_wr_ctrl (rf_wr_ctrl),
      .rf_r_ctrl  (rf_r_ctrl),
      .rf_adrs    (rf_adrs),
      .rf_in      (rf_in),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .busy       (busy),
      .done       (done),
      .win_count  (win_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard side: every DUT write must match the oldest expected write.
   always @(negedge clk) begin
      if (nrst === 1'b1) begin
         if (rf_wr_ctrl === 1'b1) begin
            logic [AW+DW-1:0] e;
            wr_cnt++;
            vectors++;
            assert (exp_q.size() != 0) else begin
               miscompares++;
               $error("FAIL unexpected_write observed addr=%0d data=%0d expected no write", rf_adrs, rf_in);
            end
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("wr_addr", 32'(rf_adrs), 32'(e[AW+DW-1:DW]));
               check("wr_data", 32'(rf_in), 32'(e[DW-1:0]));
            end
         end
         if (done === 1'b1) done_cnt++;
         check("wr_rd_exclusive", 32'(rf_wr_ctrl & rf_r_ctrl), 0);
         check("ready_while_win_valid", 32'(pix_ready & win_valid), 0);
      end
   end

   task automatic start_job(input int len, input int num);
      start       = 1'b1;
      cfg_len     = (AW+1)'(len);
      cfg_num_win = CW'(num);
      tick();
      start       = 1'b0;
      cfg_len     = 6'd3;
      cfg_num_win = 16'd7;
   endtask

   // Returns one cycle after the posedge that accepted the last pixel (N+1).
   task automatic send_pixels(input int n, input int base, input bit toggle);
      for (int i = 0; i < n; i++) begin
         if (toggle) begin
            pix_valid = 1'b0;
            pix_data  = 16'hdead;
            tick();
         end
         pix_valid = 1'b1;
         pix_data  = DW'(base + i);
         exp_q.push_back({AW'(i), DW'(base + i)});
         tick();
      end
      pix_valid = 1'b0;
      pix_data  = '0;
   endtask

   // Called at N+1: snapshot now, window one cycle later, then handshake.
   task automatic finish_window(input int stall);
      check("snap_r_ctrl", 32'(rf_r_ctrl), 1);
      check("snap_no_win_valid", 32'(win_valid), 0);
      tick();
      check("present_win_valid", 32'(win_valid), 1);
      check("present_r_ctrl_low", 32'(rf_r_ctrl), 0);
      for (int s = 0; s < stall; s++) begin
         check("stall_pix_ready", 32'(pix_ready), 0);
         tick();
         check("stall_win_valid", 32'(win_valid), 1);
      end
      win_ready = 1'b1;
      tick();
      win_ready = 1'b0;
   endtask

   initial begin
      int d0, w0;
      nrst        = 1'b1;
      start       = 1'b0;
      cfg_len     = '0;
      cfg_num_win = '0;
      pix_valid   = 1'b0;
      pix_data    = '0;
      win_ready   = 1'b0;
      #1 nrst = 1'b0;
      #2;
      check("rst_pix_ready", 32'(pix_ready), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_win_valid", 32'(win_valid), 0);
      check("rst_win_count", 32'(win_count), 0);
      check("rst_rf_r_ctrl", 32'(rf_r_ctrl), 0);
      tick();
      nrst = 1'b1;
      tick();

      // Single full window, continuous valid.
      d0 = done_cnt;
      start_job(25, 1);
      check("t1_busy", 32'(busy), 1);
      send_pixels(25, 1, 1'b0);
      finish_window(0);
      check("t1_done", 32'(done), 1);
      check("t1_win_count", 32'(win_count), 1);
      tick();
      check("t1_done_once", 32'(done), 0);
      check("t1_idle", 32'(busy), 0);
      check("t1_win_count_hold", 32'(win_count), 1);
      check("t1_done_cnt", 32'(done_cnt - d0), 1);
      check("t1_queue_empty", 32'(exp_q.size()), 0);

      // Three windows with downstream stall.
      d0 = done_cnt;
      w0 = wr_cnt;
      start_job(25, 3);
      for (int w = 0; w < 3; w++) begin
         send_pixels(25, 1000 * (w + 1), 1'b0);
         finish_window(4);
         check("t2_win_count", 32'(win_count), 32'(w + 1));
         check("t2_done", 32'(done), (w == 2) ? 1 : 0);
      end
      tick();
      check("t2_idle", 32'(busy), 0);
      check("t2_writes", 32'(wr_cnt - w0), 75);
      check("t2_done_cnt", 32'(done_cnt - d0), 1);
      check("t2_queue_empty", 32'(exp_q.size()), 0);

      // Toggling valid, short window.
      w0 = wr_cnt;
      start_job(5, 1);
      send_pixels(5, 500, 1'b1);
      finish_window(1);
      check("t3_done", 32'(done), 1);
      check("t3_writes", 32'(wr_cnt - w0), 5);
      tick();
      check("t3_queue_empty", 32'(exp_q.size()), 0);

      // cfg_len 0 clamps to the full window.
      start_job(0, 1);
      send_pixels(25, 2000, 1'b0);
      finish_window(0);
      check("t4_done", 32'(done), 1);
      tick();
      check("t4_queue_empty", 32'(exp_q.size()), 0);

      // cfg_num_win 0 finishes straight away.
      w0 = wr_cnt;
      start_job(25, 0);
      check("t5_done", 32'(done), 1);
      check("t5_win_count", 32'(win_count), 0);
      tick();
      check("t5_done_once", 32'(done), 0);
      check("t5_idle", 32'(busy), 0);
      check("t5_no_writes", 32'(wr_cnt - w0), 0);

      // Reset in the middle of FILL.
      d0 = done_cnt;
      start_job(25, 1);
      send_pixels(12, 3000, 1'b0);
      pix_valid = 1'b1;
      pix_data  = 16'd77;
      nrst      = 1'b0;
      #1;
      check("t6_pix_ready", 32'(pix_ready), 0);
      check("t6_wr_ctrl", 32'(rf_wr_ctrl), 0);
      check("t6_adrs", 32'(rf_adrs), 0);
      check("t6_rf_in", 32'(rf_in), 0);
      check("t6_busy", 32'(busy), 0);
      check("t6_win_valid", 32'(win_valid), 0);
      pix_valid = 1'b0;
      tick();
      nrst = 1'b1;
      tick();
      check("t6_no_done", 32'(done_cnt - d0), 0);
      check("t6_queue_empty", 32'(exp_q.size()), 0);
      start_job(25, 1);
      send_pixels(25, 4000, 1'b0);
      finish_window(0);
      check("t6_restart_done", 32'(done), 1);
      tick();
      check("t6_restart_queue_empty", 32'(exp_q.size()), 0);

      // Window of 9 pixels: padded in the zero-pad build, stale tail otherwise.
      start_job(9, 1);
      send_pixels(9, 5000, 1'b0);
`ifdef IMG2COL_CTRL_ZEROPAD_EN
      for (int a = 9; a < RN; a++) exp_q.push_back({AW'(a), DW'(0)});
      for (int k = 0; k < RN - 9; k++) begin
         check("t7_pad_wr", 32'(rf_wr_ctrl), 1);
         check("t7_pad_no_snap", 32'(rf_r_ctrl), 0);
         check("t7_pad_pix_ready", 32'(pix_ready), 0);
         tick();
      end
`endif
      finish_window(0);
      check("t7_done", 32'(done), 1);
      tick();
      check("t7_queue_empty", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

endmodule

// File: doc/img2col_window_ctrl.md
Name: img2col_window_ctrl

Overview:
- Controller that sequences one 2-in register file (write port plus snapshot read port) inside the img2col stage.
- Accepts a valid/ready pixel stream and writes each pixel to successive register addresses.
- When a window is complete, it issues a one-cycle snapshot read and presents the window to the downstream array with a valid/ready handshake.
- Repeats for a configured number of windows per job.

Parameters:
DATA_W, 16, pixel and register width
REG_NUM, 25, registers per window (register-file depth)
ADDR_W, 5, register address width; ceil(log2(REG_NUM)) <= ADDR_W
CNT_W, 16, width of the window counters

Ports:
clk  in  1  clock, rising edge
nrst  in  1  asynchronous active-low reset
start  in  1  job start pulse; sampled in IDLE only
cfg_len  in  ADDR_W+1  pixels per window, latched at start
cfg_num_win  in  CNT_W  windows per job, latched at start
pix_valid  in  1  input pixel valid
pix_data  in  DATA_W  input pixel
pix_ready  out  1  controller accepts pixel
rf_wr_ctrl  out  1  register-file write enable
rf_r_ctrl  out  1  register-file snapshot enable
rf_adrs  out  ADDR_W  register-file write address
rf_in  out  DATA_W  register-file write data
win_valid  out  1  register-file outputs hold a complete window
win_ready  in  1  downstream consumed window
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, job finished
win_count  out  CNT_W  windows presented so far in the current job

Behaviour:
- Reset (nrst low, async): state IDLE, all outputs 0, internal pointers/counters 0. Reset mid-job aborts the job with no done pulse.
- Config: cfg_len of 0 or > REG_NUM is clamped to REG_NUM. Latched values are used for the whole job; cfg changes while busy are ignored.
- IDLE: on start=1:
  - cfg_num_win==0 -> DONE.
  - otherwise -> FILL with wr_ptr=0, win_count=0.
  - start while busy is ignored.
- FILL:
  - pix_ready=1.
  - rf_wr_ctrl = pix_valid (combinational), rf_adrs=wr_ptr, rf_in=pix_data.
  - On each accept, wr_ptr increments.
  - The accept at wr_ptr==len-1 goes to SNAP (or PAD when the optional feature is enabled and len<REG_NUM).
  - pix_valid low stalls with no write.
- SNAP: exactly one cycle.
  - rf_r_ctrl=1, rf_wr_ctrl=0, pix_ready=0.
  - The last pixel write has landed at the prior edge, so the snapshot includes it.
  - Register-file outputs update at the end of this cycle -> PRESENT.
- PRESENT:
  - win_valid=1, pix_ready=0, rf_r_ctrl=0.
  - win_valid is held until win_ready=1; then win_count increments.
  - If win_count+1 == num_win -> DONE; else -> FILL with wr_ptr=0.
  - win_ready while win_valid=0 has no effect.
- DONE: done=1 for one cycle, then IDLE. win_count keeps its final value until the next start.
- Invariant: rf_wr_ctrl and rf_r_ctrl are never 1 in the same cycle.
- Latency:
  - Last pixel accepted at cycle N -> rf_r_ctrl at N+1 -> win_valid at N+2 (without padding).
  - Back-to-back: the first pixel of the next window can be accepted in the cycle after the win_valid/win_ready handshake.
- Minimum window period: len+2 cycles plus downstream stall.
- Registered outputs: win_valid, rf_r_ctrl, done, busy, win_count. Write-port signals are combinational from state, wr_ptr and the pixel inputs.

Optional Feature:
- Macro: IMG2COL_CTRL_ZEROPAD_EN.
- Defined:
  - When len < REG_NUM, FILL goes to PAD.
  - PAD writes zero (rf_wr_ctrl=1, rf_in=0) to addresses len..REG_NUM-1, one per cycle, with pix_ready=0, then goes to SNAP.
  - Window latency grows by REG_NUM-len cycles.
- Undefined:
  - No PAD state; addresses >= len keep stale contents (0 after reset).
  - The PAD encoding is absent.

Test Plan:
- Reset then start, cfg_len=25, cfg_num_win=1, pixels 1..25 with continuous valid:
  - writes addr 0..24 with data 1..25.
  - rf_r_ctrl high exactly 1 cycle after the 25th accept.
  - win_valid high 2 cycles after it; done 1 cycle after win_ready; win_count=1.
- cfg_num_win=3, win_ready held low 4 cycles per window:
  - pix_ready stays 0 while win_valid=1.
  - 75 writes total; win_count steps 1,2,3; single done pulse.
- pix_valid toggling 1/0, cfg_len=5: only valid cycles write; addresses 0..4 are contiguous; rf_wr_ctrl never coincides with rf_r_ctrl.
- cfg_len=0 -> behaves as 25; cfg_num_win=0 -> done one cycle after start, no writes, win_count=0.
- nrst low mid-FILL at wr_ptr=12: all outputs 0 immediately. A new start after release begins at addr 0.
- With IMG2COL_CTRL_ZEROPAD_EN, cfg_len=9: writes addr 9..24 with 0 after the 9th pixel, then SNAP; win_valid at N+18.
